pc_redirect_ctrl: RTL and testbench
===================================

# pc_redirect_ctrl

Fetch-side program counter and redirect controller for the pipelined core. Sits at the receiving end of the branch decision: it consumes the EX-stage taken signal (`switch_branch`) together with jump and target information, updates the PC, and drives the IF/ID and ID/EX flushes. It also keeps a saturating redirect counter for performance analysis.

## Interface
Parameters:
- `XLEN`, 64: PC and target width.
- `RESET_PC`, 0: PC value loaded on reset.
- `CNT_W`, 32: width of the redirect counter.

Ports:
- `clk` input 1: clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high.
- `stall` input 1: hazard-unit stall; holds the PC.
- `ex_valid` input 1: the EX-stage instruction is real (not a bubble).
- `ex_is_branch` input 1: the EX instruction is a conditional branch.
- `ex_jump` input 1: the EX instruction is an unconditional jump (jal/jalr).
- `switch_branch` input 1: branch taken, from branch control.
- `ex_target` input XLEN: resolved branch/jump target.
- `ex_pc` input XLEN: PC of the EX instruction.
- `pc` output XLEN: current fetch address.
- `if_valid` output 1: the fetch at `pc` is valid this cycle.
- `flush_if_id` output 1: squash the IF/ID register.
- `flush_id_ex` output 1: squash the ID/EX register.
- `redirect` output 1: an EX redirect is occurring this cycle.
- `misalign` output 1: sticky flag; set by a redirect target with `ex_target[1:0] != 0`.
- `redirect_count` output CNT_W: saturating count of EX redirects.
- With `BTFN_PREDICT_EN` only:
  - `id_is_branch` input 1
  - `id_target` input XLEN
  - `id_pc` input XLEN
  - `ex_pred_taken` input 1: prediction carried down the pipe with the instruction.
  - `pred_taken` output 1: prediction for the ID instruction.

## Operation
- States:
  - BOOT: the first cycle after reset. `if_valid`=0, PC held. Always moves to RUN.
  - RUN: normal fetch.
  - BUBBLE: the single cycle after an EX redirect. `if_valid`=1. Moves to RUN unless another redirect occurs in the same cycle.
- Actual taken: `act = ex_jump | (ex_is_branch & switch_branch)`.
- EX redirect, without the macro: `redirect = ex_valid & act`.
- EX redirect, with the macro: `redirect = ex_valid & (ex_jump | (ex_is_branch & (switch_branch != ex_pred_taken)))`.
- Next-PC priority, highest first:
  1. `reset`: `RESET_PC`.
  2. EX redirect: `ex_target` if `act`, else `ex_pc + 4` (a mispredicted-taken branch falls through).
  3. BOOT: hold.
  4. `stall`: hold.
  5. ID predicted-taken (macro only): `id_target`.
  6. Otherwise: `pc + 4`.
- An EX redirect overrides `stall`, because the stalled instruction is on the wrong path.
- `flush_if_id = redirect | id_redirect`.
- `flush_id_ex = redirect`.
- `id_redirect` only fires when there is no EX redirect and no stall.
- All PC arithmetic is modulo 2^XLEN; wrap-around is silent.
- `redirect_count` increments on each `redirect` cycle and saturates at 2^CNT_W-1.
- `misalign` is set on a redirect with `act` and `ex_target[1:0] != 0`. Cleared only by `reset`.
- Reset values: `pc`=`RESET_PC`, state BOOT, `if_valid`=0, `redirect_count`=0, `misalign`=0.
- Combinational outputs are 0 while `reset` is high.
- `ex_valid`=0 masks every EX input.

## Timing
- Redirect decision is combinational from the EX inputs in cycle N. `flush_*` and `redirect` are asserted in cycle N.
- `pc` = new value in cycle N+1; penalty is two squashed instructions.
- ID predicted redirect: `flush_if_id` in cycle N, `pc`=`id_target` in N+1; penalty is one instruction.
- Same-cycle EX redirect and ID prediction: EX wins, and both flushes assert.
- Reset asserted mid-redirect: reset wins, no flush is output, and the counter clears.
- `stall` held for K cycles: `pc` is constant for K cycles and advances on the first unstalled edge.

## Configuration
- `BTFN_PREDICT_EN`
  - Defined: static backward-taken/forward-not-taken prediction in ID. `pred_taken = id_is_branch & (id_target < id_pc)` (unsigned compare). The ID-side ports exist, and a correctly predicted taken branch costs one cycle instead of two.
  - Undefined: predict not-taken always. The ID ports and `pred_taken` are absent, and every taken branch or jump redirects from EX.

## Structure
- Shared package `core_pkg`:
  - state enum (`BOOT`, `RUN`, `BUBBLE`)
  - `PC_INC` = 4
  - `XLEN` default
- Sub-module `sat_counter` (parameter `W`; inputs `clk`, `reset`, `inc`; output `count`) for `redirect_count`.

## Test plan
- Reset with `RESET_PC`=0x1000, then release:
  - `if_valid`=0 for one cycle.
  - `pc` sequence 0x1000, 0x1004, 0x1008.
- With `pc`=0x20, drive `ex_valid`=1, `ex_is_branch`=1, `switch_branch`=1, `ex_target`=0x80:
  - `flush_if_id`=`flush_id_ex`=`redirect`=1 that cycle.
  - `pc`=0x80 next cycle.
  - `redirect_count`=1.
- Hold `stall`=1 for 3 cycles at `pc`=0x40 → `pc` stays 0x40. Repeat with an EX jump to 0x100 mid-stall → `pc`=0x100 next cycle.
- Drive `ex_jump` with `ex_target`=0x102:
  - `misalign`=1 and stays set until `reset`.
  - `pc`=0x102.
- Macro on: ID branch with `id_pc`=0x50, `id_target`=0x10:
  - `pred_taken`=1 and `flush_if_id`=1; next `pc`=0x10.
  - Later EX resolves not-taken with `ex_pred_taken`=1 and `ex_pc`=0x50 → `pc`=0x54 and both flushes assert.
- Force `redirect_count` to all-ones (`CNT_W`=4 instance), then apply one more redirect → count stays 15.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: types and constants shared by the fetch-side PC logic.
//   state_e      - fetch controller states (BOOT, RUN, BUBBLE)
//   PC_INC       - byte distance between sequential fetches
//   XLEN_DEFAULT - default PC / target width
package core_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        BUBBLE = 2'd2
    } state_e;

    localparam int PC_INC       = 4;
    localparam int XLEN_DEFAULT = 64;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones instead of wrapping.
//   clk   - rising-edge clock
//   reset - synchronous, active-high; clears the count
//   inc   - add one this cycle (ignored once saturated)
//   count - current count
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Stop at all-ones so long runs never wrap back to a small value.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: fetch PC register and redirect/flush control.
// Optional feature macro: BTFN_PREDICT_EN (static backward-taken /
// forward-not-taken prediction in ID; adds the id_* ports, ex_pred_taken
// and pred_taken).
//   clk, reset          - clock, synchronous active-high reset
//   stall               - hazard stall, holds the PC
//   ex_valid            - EX instruction is real; masks all other ex_* inputs
//   ex_is_branch/ex_jump- EX instruction kind
//   switch_branch       - EX branch resolved taken
//   ex_target, ex_pc    - resolved target and PC of the EX instruction
//   pc, if_valid        - fetch address and its validity
//   flush_if_id/id_ex   - pipeline squashes
//   redirect            - EX redirect happening this cycle
//   misalign            - sticky: a taken redirect had a non-word target
//   redirect_count      - saturating number of EX redirects
module pc_redirect_ctrl
    import core_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_jump,
    input  logic             switch_branch,
    input  logic [XLEN-1:0]  ex_target,
    input  logic [XLEN-1:0]  ex_pc,
`ifdef BTFN_PREDICT_EN
    input  logic             id_is_branch,
    input  logic [XLEN-1:0]  id_target,
    input  logic [XLEN-1:0]  id_pc,
    input  logic             ex_pred_taken,
    output logic             pred_taken,
`endif
    output logic [XLEN-1:0]  pc,
    output logic             if_valid,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             redirect,
    output logic             misalign,
    output logic [CNT_W-1:0] redirect_count
);

    localparam logic [XLEN-1:0] INC = XLEN'(PC_INC);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            if_valid_q, if_valid_d;
    logic            misalign_q, misalign_d;
    logic            act;
    logic            ex_redirect;
    logic            id_redirect;
    logic            id_pred;

    // Redirect decision. With prediction, a branch only redirects when the
    // resolved direction disagrees with what was predicted in ID; a wrongly
    // predicted-taken branch then falls through to ex_pc + 4.
    always_comb begin
        act         = ex_jump | (ex_is_branch & switch_branch);
        id_pred     = 1'b0;
        id_redirect = 1'b0;
`ifdef BTFN_PREDICT_EN
        ex_redirect = ~reset & ex_valid &
                      (ex_jump | (ex_is_branch & (switch_branch ^ ex_pred_taken)));
        id_pred     = ~reset & id_is_branch & (id_target < id_pc);
        // BOOT holds the PC, so an ID redirect there could not take effect.
        id_redirect = id_pred & ~ex_redirect & ~stall & (state_q != BOOT);
`else
        ex_redirect = ~reset & ex_valid & act;
`endif
    end

    // Next PC, state and sticky flag. EX redirect sits above BOOT and stall
    // because the stalled instruction is already on the wrong path.
    always_comb begin
        pc_d       = pc_q + INC;
        state_d    = RUN;
        misalign_d = misalign_q;
        if (ex_redirect) begin
            pc_d    = act ? ex_target : (ex_pc + INC);
            state_d = BUBBLE;
            if (act && (ex_target[1:0] != 2'b00)) begin
                misalign_d = 1'b1;
            end
        end else if (state_q == BOOT || stall) begin
            pc_d = pc_q;
        end else if (id_redirect) begin
`ifdef BTFN_PREDICT_EN
            pc_d = id_target;
`else
            pc_d = pc_q;
`endif
        end
        if_valid_d = (state_d != BOOT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            misalign_q <= misalign_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_redirect_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ex_redirect),
        .count (redirect_count)
    );

    assign pc          = pc_q;
    assign if_valid    = if_valid_q;
    assign misalign    = misalign_q;
    assign redirect    = ex_redirect;
    assign flush_id_ex = ex_redirect;
    assign flush_if_id = ex_redirect | id_redirect;
`ifdef BTFN_PREDICT_EN
    assign pred_taken  = id_pred;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: scoreboard bench for pc_redirect_ctrl. A driver applies
// one stimulus per cycle and pushes the response a spec-level model predicts;
// a monitor pops and compares at every falling edge.
module tb_pc_redirect_ctrl;

    localparam logic [63:0] RST_PC = 64'h1000;
    localparam int          CW     = 4;

    typedef struct {
        bit          rst, stall, exv, exbr, exj, sw, expred, idbr;
        logic [63:0] tgt, expc, idtgt, idpc;
    } stim_t;

    typedef struct {
        logic [63:0] pc;
        bit          ifv, fif, fie, rd, mis, pred;
        int          cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          stall = 1'b0, ex_valid = 1'b0, ex_is_branch = 1'b0;
    logic          ex_jump = 1'b0, switch_branch = 1'b0;
    logic [63:0]   ex_target = '0, ex_pc = '0;
    logic          id_is_branch = 1'b0, ex_pred_taken = 1'b0;
    logic [63:0]   id_target = '0, id_pc = '0;
    logic          pred_taken;
    logic [63:0]   pc;
    logic          if_valid, flush_if_id, flush_id_ex, redirect, misalign;
    logic [CW-1:0] redirect_count;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    // Spec-level model state
    bit          m_known = 0;
    logic [63:0] m_pc;
    bit          m_boot, m_mis;
    int          m_cnt;

    always #5 clk = ~clk;

    pc_redirect_ctrl #(
        .XLEN     (64),
        .RESET_PC (RST_PC),
        .CNT_W    (CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_jump        (ex_jump),
        .switch_branch  (switch_branch),
        .ex_target      (ex_target),
        .ex_pc          (ex_pc),
`ifdef BTFN_PREDICT_EN
        .id_is_branch   (id_is_branch),
        .id_target      (id_target),
        .id_pc          (id_pc),
        .ex_pred_taken  (ex_pred_taken),
        .pred_taken     (pred_taken),
`endif
        .pc             (pc),
        .if_valid       (if_valid),
        .flush_if_id    (flush_if_id),
        .flush_id_ex    (flush_id_ex),
        .redirect       (redirect),
        .misalign       (misalign),
        .redirect_count (redirect_count)
    );

`ifndef BTFN_PREDICT_EN
    assign pred_taken = 1'b0;
`endif

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, predict the DUT response from the spec rules
    // and advance the model to the state after the next rising edge.
    task automatic applyStimulus(input stim_t s);
        exp_t e;
        bit   act, rd, pred, idr;
        @(posedge clk);
        #1;
        reset         = s.rst;
        stall         = s.stall;
        ex_valid      = s.exv;
        ex_is_branch  = s.exbr;
        ex_jump       = s.exj;
        switch_branch = s.sw;
        ex_target     = s.tgt;
        ex_pc         = s.expc;
        ex_pred_taken = s.expred;
        id_is_branch  = s.idbr;
        id_target     = s.idtgt;
        id_pc         = s.idpc;

        act = s.exj || (s.exbr && s.sw);
`ifdef BTFN_PREDICT_EN
        rd   = !s.rst && s.exv && (s.exj || (s.exbr && (s.sw != s.expred)));
        pred = !s.rst && s.idbr && (s.idtgt < s.idpc);
`else
        rd   = !s.rst && s.exv && act;
        pred = 0;
`endif
        idr = pred && !rd && !s.stall && !m_boot;

        if (m_known) begin
            e.pc   = m_pc;
            e.ifv  = !m_boot;
            e.mis  = m_mis;
            e.cnt  = m_cnt;
            e.rd   = rd;
            e.fie  = rd;
            e.fif  = rd || idr;
            e.pred = pred;
            sb_q.push_back(e);
        end

        if (s.rst) begin
            m_pc   = RST_PC;
            m_boot = 1;
            m_mis  = 0;
            m_cnt  = 0;
        end else begin
            if (rd) m_pc = act ? s.tgt : s.expc + 64'd4;
            else if (m_boot || s.stall) m_pc = m_pc;
            else if (idr) m_pc = s.idtgt;
            else m_pc = m_pc + 64'd4;
            if (rd && act && (s.tgt % 4 != 0)) m_mis = 1;
            m_cnt = (m_cnt + int'(rd) > 15) ? 15 : m_cnt + int'(rd);
            m_boot = 0;
        end
        m_known = 1;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic stim_t jump_to(input logic [63:0] t);
        stim_t s;
        s = idle();
        s.exv = 1; s.exj = 1; s.tgt = t; s.expc = 64'h8;
        return s;
    endfunction

    // Monitor: compare every presented cycle against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checkOutput("pc", pc, e.pc);
                checkOutput("if_valid", 64'(if_valid), 64'(e.ifv));
                checkOutput("flush_if_id", 64'(flush_if_id), 64'(e.fif));
                checkOutput("flush_id_ex", 64'(flush_id_ex), 64'(e.fie));
                checkOutput("redirect", 64'(redirect), 64'(e.rd));
                checkOutput("misalign", 64'(misalign), 64'(e.mis));
                checkOutput("redirect_count", 64'(redirect_count), 64'(e.cnt));
                checkOutput("pred_taken", 64'(pred_taken), 64'(e.pred));
            end
        end
    end

    initial begin
        stim_t s;
        s = idle(); s.rst = 1;
        repeat (3) applyStimulus(s);
        // Boot cycle then sequential fetch from RESET_PC
        repeat (4) applyStimulus(idle());

        // Taken branch from 0x20 to 0x80
        applyStimulus(jump_to(64'h20));
        s = idle(); s.exv = 1; s.exbr = 1; s.sw = 1; s.tgt = 64'h80; s.expc = 64'h20;
        applyStimulus(s);
        repeat (2) applyStimulus(idle());

        // Stall holds, then a jump mid-stall wins
        applyStimulus(jump_to(64'h40));
        s = idle(); s.stall = 1;
        repeat (3) applyStimulus(s);
        s = jump_to(64'h100); s.stall = 1;
        applyStimulus(s);
        s = idle(); s.stall = 1;
        applyStimulus(s);
        applyStimulus(idle());

        // Not-taken branch and a bubble-masked jump do not redirect
        s = idle(); s.exv = 1; s.exbr = 1; s.sw = 0; s.tgt = 64'h300;
        applyStimulus(s);
        s = jump_to(64'h500); s.exv = 0;
        applyStimulus(s);

        // Misaligned jump target, flag sticks
        applyStimulus(jump_to(64'h102));
        repeat (3) applyStimulus(idle());

`ifdef BTFN_PREDICT_EN
        // Backward ID branch predicted taken, then EX finds it not taken
        s = idle(); s.idbr = 1; s.idpc = 64'h50; s.idtgt = 64'h10;
        applyStimulus(s);
        s = idle(); s.exv = 1; s.exbr = 1; s.sw = 0; s.expred = 1; s.expc = 64'h50;
        applyStimulus(s);
        applyStimulus(idle());
        // Same-cycle EX redirect and ID prediction
        s = jump_to(64'h200); s.idbr = 1; s.idpc = 64'h90; s.idtgt = 64'h30;
        applyStimulus(s);
        applyStimulus(idle());
`endif

        // Back-to-back redirects drive the counter into saturation
        for (int i = 0; i < 18; i++) applyStimulus(jump_to(64'h600 + 64'(i * 4)));

        // Reset during a redirect: reset wins and clears the counter and flag
        s = jump_to(64'h700); s.rst = 1;
        applyStimulus(s);
        repeat (3) applyStimulus(idle());

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            s = idle();
            s.rst    = ($urandom_range(0, 49) == 0);
            s.stall  = ($urandom_range(0, 3) == 0);
            s.exv    = $urandom_range(0, 1);
            s.exbr   = $urandom_range(0, 1);
            s.exj    = ($urandom_range(0, 3) == 0);
            s.sw     = $urandom_range(0, 1);
            s.expred = $urandom_range(0, 1);
            s.tgt    = {$urandom, $urandom};
            if ($urandom_range(0, 7) != 0) s.tgt[1:0] = 2'b00;
            s.expc   = {$urandom, $urandom};
            s.idbr   = $urandom_range(0, 1);
            s.idtgt  = {$urandom, $urandom};
            s.idpc   = {$urandom, $urandom};
            applyStimulus(s);
        end

        // Let the monitor drain; a leftover entry counts as a failure.
        repeat (3) @(posedge clk);
        if (sb_q.size() != 0) checkOutput("scoreboard_drain", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
